// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one read or write per request against a local word RAM.
// Latency: mem_stall is high for LATENCY+1 cycles from the request; the result is presented in the DONE cycle that follows.
// Backpressure: mem_stall is combinational and holds the pipeline until DONE; a withdrawn request aborts with no side effects.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  req;
  logic                  fault;
  logic                  commit;
  logic                  wr_commit;
  logic                  rd_commit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [31:0]           ram [DEPTH];

  assign req       = mem_ren | mem_wen;
  assign mem_stall = req & (state != DONE);
  assign word_idx  = mem_addr[ADDR_WIDTH+1:2];

  // Misaligned, beyond the RAM, or an ambiguous read+write request.
  assign fault = (mem_addr[1:0] != 2'b00)
               | ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0)
               | (mem_ren & mem_wen);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A read+write clash is handled as a (faulting) write, so it never touches mem_din.
  assign wr_commit = commit & mem_wen & ~fault;
  assign rd_commit = commit & mem_ren & ~mem_wen;
  assign rd_word   = ram[word_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din <= 32'd0;
      mem_err <= 1'b0;
    end else begin
      if (rd_commit) begin
        mem_din <= fault ? 32'd0 : rd_word;
      end
      if (commit) begin
        mem_err <= fault;
      end else if (state == DONE) begin
        mem_err <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; the write is gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      ram[word_idx] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three builds (LATENCY 2, 1, 15) driven one at a time by directed and random accesses.
module tb_dmem_responder;

  typedef struct {
    int          d;
    logic [31:0] din;
    logic        err;
    int          slen;
    int          tag;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] din;
  } idle_t;

  logic        clk;
  logic        rst_n;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] dout  [3];
  logic [31:0] din   [3];
  logic        stall [3];
  logic        err   [3];

  exp_t        exp_q[$];
  idle_t       idle_q[$];
  logic [31:0] mdl [3][1024];
  logic [31:0] last_din [3];
  int          scnt [3];
  logic        clr [3];
  int          n_tests;
  int          n_fail;
  int          tag_ctr;
  logic        end_req;
  logic        mon_done;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_ren  (ren[g]),
      .mem_wen  (wen[g]),
      .mem_addr (addr[g]),
      .mem_dout (dout[g]),
      .mem_din  (din[g]),
      .mem_stall(stall[g]),
      .mem_err  (err[g])
    );
  end

  task automatic check(input string nm, input int d, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d acc%0d: got %h, expected %h", nm, d, tag, act, exp);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    exp_t  e;
    idle_t ic;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        check("rst_din", g, -1, din[g], 32'd0);
        check("rst_err", g, -1, {31'd0, err[g]}, 32'd0);
        check("rst_stall", g, -1, {31'd0, stall[g]}, 32'd0);
        scnt[g] = 0;
        clr[g]  = 1'b0;
      end else begin
        if (clr[g]) begin
          check("err_clear", g, -1, {31'd0, err[g]}, 32'd0);
          clr[g] = 1'b0;
        end
        if ((ren[g] | wen[g]) && stall[g]) begin
          scnt[g]++;
        end else if (ren[g] | wen[g]) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: got DONE, expected no access", g);
          end else begin
            e = exp_q.pop_front();
            check("dut_id", g, e.tag, g, e.d);
            check("din", g, e.tag, din[g], e.din);
            check("err", g, e.tag, {31'd0, err[g]}, {31'd0, e.err});
            check("stall_len", g, e.tag, scnt[g], e.slen);
          end
          scnt[g] = 0;
          clr[g]  = 1'b1;
        end else begin
          scnt[g] = 0;
          if (idle_q.size() != 0 && idle_q[0].d == g) begin
            ic = idle_q.pop_front();
            check("idle_stall", g, -1, {31'd0, stall[g]}, 32'd0);
            check("idle_din", g, -1, din[g], ic.din);
            check("idle_err", g, -1, {31'd0, err[g]}, 32'd0);
          end
        end
      end
    end
    if (end_req && !mon_done) begin
      check("exp_q_left", -1, -1, exp_q.size(), 32'd0);
      check("idle_q_left", -1, -1, idle_q.size(), 32'd0);
      mon_done = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input int d);
    idle_t ic;
    ic.d   = d;
    ic.din = last_din[d];
    idle_q.push_back(ic);
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE cycle with the request dropped.
  task automatic access(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    logic flt;
    int   k;
    flt = (a[1:0] != 2'b00) || (a[31:12] != 20'd0) || (r && w);
    if (w) begin
      if (!flt) mdl[d][a[11:2]] = dat;
    end else if (r) begin
      last_din[d] = flt ? 32'd0 : mdl[d][a[11:2]];
    end
    e.d    = d;
    e.din  = last_din[d];
    e.err  = flt;
    e.slen = lat_of(d) + 1;
    e.tag  = tag_ctr;
    tag_ctr++;
    exp_q.push_back(e);
    ren[d]  = r;
    wen[d]  = w;
    addr[d] = a;
    dout[d] = dat;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (stall[d] && k < 40);
    if (stall[d]) begin
      $display("FAIL timeout dut%0d acc%0d: stall still high after %0d cycles, expected DONE", d, e.tag, k);
      $fatal(1, "access timeout");
    end
    @(posedge clk);
    #1;
    ren[d] = 1'b0;
    wen[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          op;
    n_tests  = 0;
    n_fail   = 0;
    tag_ctr  = 0;
    end_req  = 1'b0;
    mon_done = 1'b0;
    rst_n    = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ren[g]      = 1'b0;
      wen[g]      = 1'b0;
      addr[g]     = 32'd0;
      dout[g]     = 32'd0;
      last_din[g] = 32'd0;
      scnt[g]     = 0;
      clr[g]      = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read at LATENCY=2; back-to-back write/read of word 0.
    access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0);
    access(0, 1'b0, 1'b1, 32'h0, 32'h11111111);
    access(0, 1'b1, 1'b0, 32'h0, 32'd0);

    // Reset in the middle of a write to 0x10 must not disturb RAM[4].
    access(0, 1'b0, 1'b1, 32'h10, 32'hCAFE0001);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0);
    wen[0]  = 1'b1;
    addr[0] = 32'h10;
    dout[0] = 32'hBADBAD00;
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    wen[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int g = 0; g < 3; g++) last_din[g] = 32'd0;
    push_idle(0);
    idle(2);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0);

    // Faults: misaligned read, out-of-range write, read+write clash.
    access(0, 1'b1, 1'b0, 32'h42, 32'd0);
    access(0, 1'b0, 1'b1, 32'h1000, 32'hFFFF0000);
    access(0, 1'b1, 1'b0, 32'h0, 32'd0);
    access(0, 1'b1, 1'b1, 32'h40, 32'h12345678);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0);

    // Flush: write withdrawn in its first BUSY cycle.
    access(0, 1'b0, 1'b1, 32'h8, 32'h01234567);
    wen[0]  = 1'b1;
    addr[0] = 32'h8;
    dout[0] = 32'h5A5A5A5A;
    @(posedge clk);
    #1 wen[0] = 1'b0;
    push_idle(0);
    idle(2);
    access(0, 1'b1, 1'b0, 32'h8, 32'd0);

    // LATENCY=1 and LATENCY=15 builds: seed 16 words, then mixed traffic.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        a = 32'(i) << 2;
        access(d, 1'b0, 1'b1, a, $urandom);
      end
      for (int i = 0; i < 40; i++) begin
        w = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          0:       a = {26'd0, w, 2'($urandom_range(1, 3))};
          1:       a = {26'd0, w, 2'b00} | (32'h1 << $urandom_range(12, 31));
          default: a = {26'd0, w, 2'b00};
        endcase
        op = $urandom_range(0, 9);
        if (op < 4)      access(d, 1'b0, 1'b1, a, $urandom);
        else if (op < 9) access(d, 1'b1, 1'b0, a, 32'd0);
        else             access(d, 1'b1, 1'b1, a, $urandom);
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) @(posedge clk);
    if (!mon_done) $display("FAIL end_check: monitor did not finish, expected final queue check");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
